ring_sequence_checker: RTL and testbench
========================================

Name: ring_sequence_checker

Overview:
- Receive-side monitor for the one-hot ring counter output bus.
- Samples the N-bit ring code and checks that it is one-hot.
- Checks that each new code is the expected rotation of the previous code.
- Encodes the hot-bit position to binary, tracks lock status and counts sequence faults for debug and status registers.

Parameters:
N, 3, ring width; legal range N >= 2
LOCK_CNT, 4, consecutive legal steps needed to declare lock; range 1..15
ERR_W, 8, width of the saturating error counter
DIR_DOWN, 1, 1: hot bit moves N-1 -> ... -> 0 -> N-1 (e.g. 100, 010, 001, 100); 0: opposite direction

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  sample enable; ring_in is evaluated only on edges where en=1
ring_in  input  N  ring code under test; must be stable at the rising edge
clr_err  input  1  synchronous clear of err_cnt
idx  output  clog2(N)  binary position of the hot bit in the last valid code
valid_code  output  1  last sample was one-hot
locked  output  1  checker is in LOCKED
seq_err  output  1  one-cycle pulse per fault detected while LOCKED
err_cnt  output  ERR_W  saturating fault count

Behaviour:
- Reset: async assertion forces state=UNLOCKED, good_cnt=0, prev code=0, idx=0, valid_code=0, locked=0, seq_err=0, err_cnt=0; effect is immediate, not clock-gated.
- All outputs are registered. Latency is 1: outputs reflect the ring_in captured at the same enabled edge.
- en=0: all state holds; seq_err=0 on that cycle.
- Classification of each enabled sample against the stored previous valid code:
  - INVALID: zero or multi-hot.
  - HOLD: equal to previous.
  - STEP: the expected rotation, including wrap bit0 <-> bit N-1 per DIR_DOWN.
  - BAD: one-hot but neither HOLD nor STEP (skip or reverse).
- idx/prev: updated on every one-hot sample. On INVALID, idx and prev hold their old values and valid_code=0.
- FSM states: UNLOCKED, TRACK, LOCKED, FAULT.
  - UNLOCKED: one-hot -> TRACK with good_cnt=0. INVALID -> stay.
  - TRACK: STEP -> good_cnt+1; when good_cnt reaches LOCK_CNT -> LOCKED (locked=1 at that same edge). HOLD -> stay, count unchanged. BAD -> TRACK with good_cnt=0 and new prev. INVALID -> UNLOCKED.
  - LOCKED: STEP or HOLD -> stay. BAD or INVALID -> FAULT, seq_err=1 for one cycle, err_cnt increments.
  - FAULT: locked=0, no further seq_err. One-hot -> TRACK with good_cnt=0. INVALID -> stay.
- err_cnt:
  - Saturates at all ones and never wraps.
  - clr_err alone sets it to 0.
  - clr_err in the same cycle as a fault gives err_cnt=1; clear is applied first, then the increment.
- Faults detected in UNLOCKED or TRACK never pulse seq_err or increment err_cnt.
- good_cnt width is 4 bits.

Decomposition:
- Shared package ring_pkg holds:
  - state enum {UNLOCKED, TRACK, LOCKED, FAULT}
  - step-class enum {INVALID, HOLD, STEP, BAD}
  - function ring_next(code, dir) returning the expected rotation
  - constant default width 3, shared with the ring counter
- One sub-module: ring_onehot_decode. It is purely combinational: N-bit input, outputs is_onehot and binary idx. It is reusable by other ring consumers.

Test Plan:
1. N=3, LOCK_CNT=4, DIR_DOWN=1. After reset, drive 100, 010, 001, 100, 010 with en=1 -> idx = 2, 1, 0, 2, 1; valid_code=1 throughout; locked=1 from the 5th edge onward; seq_err never asserted.
2. While locked, drive 011 -> seq_err pulses for exactly one cycle, err_cnt=1, valid_code=0, idx holds 1, locked=0. Then drive 001, 100, 010, 001, 100 -> re-lock on the 5th sample.
3. While locked with prev=010, drive 100 (reverse step) -> seq_err pulse, err_cnt increments, state FAULT. Then drive 000 twice -> no further seq_err, locked stays 0.
4. In TRACK, repeat 010 for 3 samples, then toggle en=0 for 2 cycles with garbage on ring_in -> good_cnt, idx and outputs unchanged; lock is still reached after 4 total STEPs.
5. ERR_W=2: induce 5 faults, re-locking in between -> err_cnt saturates at 3. Then assert clr_err on the same edge as a 6th fault -> err_cnt=1.
6. Assert rst asynchronously midway between edges while LOCKED -> locked, idx, valid_code and err_cnt read 0 before the next clock edge. Deassert, then repeat scenario 1 -> identical results.

Source files
------------

// File: rtl/ring_pkg.sv
// Shared types and helpers for one-hot ring counters and their receive-side checkers.
package ring_pkg;

    localparam int RING_DEF_W = 3;
    localparam int RING_MAX_W = 32;

    typedef enum logic [1:0] {UNLOCKED, TRACK, LOCKED, FAULT} ring_state_t;
    typedef enum logic [1:0] {INVALID, HOLD, STEP, BAD} step_class_t;

    // Expected successor of an n-bit ring code held in the low bits of a RING_MAX_W word.
    // dir=1 moves the hot bit toward bit 0 and wraps bit 0 back to bit n-1.
    function automatic logic [RING_MAX_W-1:0] ring_next(input logic [RING_MAX_W-1:0] code,
                                                        input int n, input logic dir);
        logic [RING_MAX_W-1:0] mask;
        mask = (RING_MAX_W'(1) << n) - RING_MAX_W'(1);
        if (dir)
            ring_next = ((code & mask) >> 1) | (RING_MAX_W'(code[0]) << (n - 1));
        else
            ring_next = ((code << 1) & mask) | ((code >> (n - 1)) & RING_MAX_W'(1));
    endfunction

endpackage

// File: rtl/ring_onehot_decode.sv
// Combinational one-hot detector and hot-bit position encoder for ring codes.
module ring_onehot_decode #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     code,
    output logic             is_onehot,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        is_onehot = (code != '0) && ((code & (code - N'(1))) == '0);
        idx       = '0;
        // OR of set-bit positions; only meaningful when is_onehot is high
        for (int i = 0; i < N; i++)
            if (code[i]) idx = idx | IDX_W'(i);
    end

endmodule

// File: rtl/ring_sequence_checker.sv
// Receive-side monitor for a one-hot ring bus: validates codes and rotation order,
// tracks lock and counts faults seen while locked.
module ring_sequence_checker
    import ring_pkg::*;
#(
    parameter int N        = RING_DEF_W,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8,
    parameter bit DIR_DOWN = 1'b1,
    localparam int IDX_W   = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     ring_in,
    input  logic             clr_err,
    output logic [IDX_W-1:0] idx,
    output logic             valid_code,
    output logic             locked,
    output logic             seq_err,
    output logic [ERR_W-1:0] err_cnt
);

    ring_state_t      state, state_nx;
    step_class_t      cls;
    logic [3:0]       good_cnt, good_nx, good_inc;
    logic [N-1:0]     prev;
    logic             oh, fault;
    logic [IDX_W-1:0] dec_idx;
    logic [ERR_W-1:0] err_nx;

    ring_onehot_decode #(.N(N), .IDX_W(IDX_W)) u_dec (
        .code      (ring_in),
        .is_onehot (oh),
        .idx       (dec_idx)
    );

    always_comb begin
        cls = INVALID;
        if (oh) begin
            if (ring_in == prev)
                cls = HOLD;
            else if (RING_MAX_W'(ring_in) == ring_next(RING_MAX_W'(prev), N, DIR_DOWN))
                cls = STEP;
            else
                cls = BAD;
        end
    end

    always_comb begin
        state_nx = state;
        good_nx  = good_cnt;
        fault    = 1'b0;
        good_inc = good_cnt + 4'd1;
        if (en) begin
            unique case (state)
                UNLOCKED: if (oh) begin state_nx = TRACK; good_nx = '0; end
                TRACK: begin
                    unique case (cls)
                        STEP: begin
                            good_nx = good_inc;
                            if (good_inc == 4'(LOCK_CNT)) state_nx = LOCKED;
                        end
                        HOLD:    ;
                        BAD:     good_nx = '0;
                        INVALID: begin state_nx = UNLOCKED; good_nx = '0; end
                    endcase
                end
                LOCKED: if (cls == BAD || cls == INVALID) begin
                    state_nx = FAULT;
                    fault    = 1'b1;
                end
                FAULT: if (oh) begin state_nx = TRACK; good_nx = '0; end
            endcase
        end
    end

    // Clear wins over the stored count, then a same-cycle fault still counts once.
    always_comb begin
        err_nx = clr_err ? '0 : err_cnt;
        if (fault && err_nx != '1) err_nx = err_nx + ERR_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= UNLOCKED;
            good_cnt   <= '0;
            prev       <= '0;
            idx        <= '0;
            valid_code <= 1'b0;
            locked     <= 1'b0;
            seq_err    <= 1'b0;
            err_cnt    <= '0;
        end else begin
            state    <= state_nx;
            good_cnt <= good_nx;
            locked   <= (state_nx == LOCKED);
            seq_err  <= fault;
            err_cnt  <= err_nx;
            if (en) begin
                valid_code <= oh;
                if (oh) begin
                    prev <= ring_in;
                    idx  <= dec_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_ring_sequence_checker.sv
// Directed bench for ring_sequence_checker; a second instance with a 2-bit error counter shares the stimulus.
module tb_ring_sequence_checker;

    logic       clk = 1'b0, rst = 1'b1, en = 1'b0, clr_err = 1'b0;
    logic [2:0] ring_in = 3'b000;
    logic [1:0] idx, idx2;
    logic       valid_code, locked, seq_err, vc2, lk2, se2;
    logic [7:0] err_cnt;
    logic [1:0] err2;
    int         n_chk = 0, n_fail = 0;

    logic [2:0] s1_code [5] = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b010};
    int         s1_idx  [5] = '{2, 1, 0, 2, 1};

    always #5 clk = ~clk;

    ring_sequence_checker #(.N(3), .LOCK_CNT(4), .ERR_W(8), .DIR_DOWN(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .ring_in(ring_in), .clr_err(clr_err),
        .idx(idx), .valid_code(valid_code), .locked(locked), .seq_err(seq_err), .err_cnt(err_cnt)
    );

    ring_sequence_checker #(.N(3), .LOCK_CNT(4), .ERR_W(2), .DIR_DOWN(1'b1)) dut2 (
        .clk(clk), .rst(rst), .en(en), .ring_in(ring_in), .clr_err(clr_err),
        .idx(idx2), .valid_code(vc2), .locked(lk2), .seq_err(se2), .err_cnt(err2)
    );

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] code, input logic e, input logic c);
        ring_in = code;
        en      = e;
        clr_err = c;
        @(posedge clk);
        #1;
        en      = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic chk_out(input string tag, input int ix, input int vc, input int lk,
                           input int se, input int ec);
        check({tag, ".idx"},    int'(idx),        ix);
        check({tag, ".valid"},  int'(valid_code), vc);
        check({tag, ".locked"}, int'(locked),     lk);
        check({tag, ".seq_err"},int'(seq_err),    se);
        check({tag, ".err"},    int'(err_cnt),    ec);
    endtask

    task automatic scen1(input string tag);
        for (int i = 0; i < 5; i++) begin
            drive(s1_code[i], 1'b1, 1'b0);
            chk_out($sformatf("%s[%0d]", tag, i), s1_idx[i], 1, (i == 4) ? 1 : 0, 0, 0);
        end
    endtask

    task automatic relock(input string tag);
        for (int i = 0; i < 5; i++) drive(s1_code[i], 1'b1, 1'b0);
        check({tag, ".relocked"}, int'(locked), 1);
    endtask

    initial begin
        #1;
        chk_out("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: clean lock on the 5th sample
        scen1("s1");

        // 2: multi-hot while locked, then re-lock
        drive(3'b011, 1'b1, 1'b0);
        chk_out("s2.fault", 1, 0, 0, 1, 1);
        drive(3'b001, 1'b1, 1'b0);
        chk_out("s2.after", 0, 1, 0, 0, 1);
        drive(3'b100, 1'b1, 1'b0);
        drive(3'b010, 1'b1, 1'b0);
        drive(3'b001, 1'b1, 1'b0);
        check("s2.not_yet", int'(locked), 0);
        drive(3'b100, 1'b1, 1'b0);
        chk_out("s2.relock", 2, 1, 1, 0, 1);

        // 3: reverse step while locked, then invalid codes in FAULT
        drive(3'b010, 1'b1, 1'b0);
        chk_out("s3.step", 1, 1, 1, 0, 1);
        drive(3'b100, 1'b1, 1'b0);
        chk_out("s3.rev", 2, 1, 0, 1, 2);
        drive(3'b000, 1'b1, 1'b0);
        chk_out("s3.z0", 2, 0, 0, 0, 2);
        drive(3'b000, 1'b1, 1'b0);
        chk_out("s3.z1", 2, 0, 0, 0, 2);

        // 4: holds in TRACK and disabled cycles do not disturb progress
        for (int i = 0; i < 3; i++) begin
            drive(3'b010, 1'b1, 1'b0);
            chk_out($sformatf("s4.hold%0d", i), 1, 1, 0, 0, 2);
        end
        drive(3'b111, 1'b0, 1'b0);
        chk_out("s4.en0a", 1, 1, 0, 0, 2);
        drive(3'b011, 1'b0, 1'b0);
        chk_out("s4.en0b", 1, 1, 0, 0, 2);
        drive(3'b001, 1'b1, 1'b0);
        drive(3'b100, 1'b1, 1'b0);
        drive(3'b010, 1'b1, 1'b0);
        check("s4.three_steps", int'(locked), 0);
        drive(3'b001, 1'b1, 1'b0);
        chk_out("s4.lock", 0, 1, 1, 0, 2);

        // clear alone, while locked and holding
        check("clr.pre2", int'(err2), 2);
        drive(3'b001, 1'b1, 1'b1);
        chk_out("clr.only", 0, 1, 1, 0, 0);
        check("clr.only2", int'(err2), 0);

        // 5: five faults, 2-bit counter saturates at 3
        for (int k = 0; k < 5; k++) begin
            drive(3'b000, 1'b1, 1'b0);
            check($sformatf("s5.se%0d", k),   int'(seq_err), 1);
            check($sformatf("s5.err8_%0d", k), int'(err_cnt), k + 1);
            check($sformatf("s5.err2_%0d", k), int'(err2), (k < 3) ? k + 1 : 3);
            relock($sformatf("s5.rl%0d", k));
        end
        drive(3'b000, 1'b1, 1'b1);
        check("s5.clr_fault_se", int'(seq_err), 1);
        check("s5.clr_fault8",   int'(err_cnt), 1);
        check("s5.clr_fault2",   int'(err2), 1);

        // 6: asynchronous reset between edges while locked
        relock("s6.pre");
        check("s6.pre_err", int'(err_cnt), 1);
        #3;
        rst = 1'b1;
        #1;
        chk_out("s6.async", 0, 0, 0, 0, 0);
        check("s6.async_err2", int'(err2), 0);
        @(negedge clk);
        rst = 1'b0;
        scen1("s6.s1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
